// File: rtl/alu_seq.sv
// Registered WIDTH-generic ALU with valid/ready handshakes on both sides.
// Define ALU_MUL_EN to enable the iterative shift-add multiplier for mode 7.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flag
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_W = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd1
`ifdef ALU_MUL_EN
    , MUL = 2'd2
`endif
  } state_t;

  state_t           state;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_z;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign sh       = operand1[SHW-1:0];

  // Single-cycle datapath; sum carries one extra bit for carry/borrow out.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (mode)
      4'd0: begin
        sum     = {1'b0, operand1} + {1'b0, operand2};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (operand1[MSB] == operand2[MSB]) && (alu_res[MSB] != operand1[MSB]);
      end
      4'd1: begin
        sum     = {1'b0, operand1} - {1'b0, operand2};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (operand1[MSB] != operand2[MSB]) && (alu_res[MSB] != operand1[MSB]);
      end
      4'd2:  alu_res = operand1;
      4'd3:  alu_res = operand2;
      4'd4:  alu_res = operand1 & operand2;
      4'd5:  alu_res = operand1 | operand2;
      4'd6:  alu_res = operand1 ^ operand2;
      4'd8: begin
        sum     = {1'b0, operand2} + ONE_W;
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = !operand2[MSB] && alu_res[MSB];
      end
      4'd9: begin
        sum     = {1'b0, operand1} + ONE_W;
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = !operand1[MSB] && alu_res[MSB];
      end
      4'd10: alu_res = {operand2[MSB-1:0], operand2[MSB]};
      4'd11: alu_res = {operand1[0], operand1[MSB:1]};
      4'd12: alu_res = operand2 << sh;
      4'd13: alu_res = operand2 >> sh;
      4'd14: alu_res = $signed(operand2) >>> sh;
      4'd15: begin
        sum     = '0 - {1'b0, operand2};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = operand2[MSB] && alu_res[MSB];
      end
      default: alu_res = '0;
    endcase
    // Mode 7 on this path is the illegal-op marker, so its zero flag stays low.
    alu_z = (alu_res == '0) && (mode != 4'd7);
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_reg;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   mcand_reg;
  logic [SHW-1:0]     cnt_reg;
  logic [WIDTH:0]     psum;

  // Upper half accumulates, lower half holds the remaining multiplier bits.
  always_comb begin
    psum      = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, (prod_reg[0] ? mcand_reg : '0)};
    prod_next = {psum, prod_reg[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flag      <= '0;
`ifdef ALU_MUL_EN
      prod_reg  <= '0;
      mcand_reg <= '0;
      cnt_reg   <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_MUL_EN
      if (mode == 4'd7) begin
        state     <= MUL;
        out_valid <= 1'b0;
        prod_reg  <= {{WIDTH{1'b0}}, operand2};
        mcand_reg <= operand1;
        cnt_reg   <= '0;
      end else
`endif
      begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= alu_res;
        result_hi <= '0;
        flag      <= {alu_z, alu_c, alu_v, alu_res[MSB]};
      end
    end else begin
      case (state)
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          prod_reg <= prod_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == SHW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= prod_next[MSB:0];
            result_hi <= prod_next[2*WIDTH-1:WIDTH];
            flag      <= {(prod_next == '0), |prod_next[2*WIDTH-1:WIDTH], 1'b0,
                          prod_next[2*WIDTH-1]};
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
